// File: rtl/xd_pulse_sync.sv
// xd_pulse_sync: multi-channel synchroniser for asynchronous event strobes.
// Each channel: STAGES-flop synchroniser -> edge detector (MODE) -> one
// registered single-cycle pulse per edge, with an optional per-channel holdoff
// that drops edges arriving too soon after a pulse and counts them in a
// saturating drop counter. A shared prime counter masks the start-up transient
// after reset so that inputs already high at reset never produce a pulse.
module xd_pulse_sync #(
  parameter int CH      = 4,
  parameter int STAGES  = 2,
  parameter int MODE    = 0,
  parameter int HOLDOFF = 0,
  parameter int CNTW    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [CH-1:0]        async_i,
  input  logic [CH-1:0]        en_i,
  input  logic                 clr_i,
  output logic [CH-1:0]        o,
  output logic [CH-1:0]        lvl_o,
  output logic [CH-1:0]        drop_o,
  output logic [CH*CNTW-1:0]   drop_cnt
);

  // The prime counter must reach STAGES+1; one extra count so the edge register
  // has caught up with a fully filled sync chain before detection is trusted.
  localparam int              PW         = $clog2(STAGES + 2);
  localparam logic [PW-1:0]   PRIME_LAST = PW'(STAGES + 1);
  localparam logic [CNTW-1:0] CNT_MAX    = '1;

  logic [PW-1:0] prime_reg;
  logic          primed;

  assign primed = (prime_reg == PRIME_LAST);

  // Shared prime counter: counts up after reset release and then parks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prime_reg <= '0;
    end else if (!primed) begin
      prime_reg <= prime_reg + 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic [STAGES-1:0] sync_reg;
      logic              prev_reg;
      logic              pulse_reg;
      logic              drop_reg;
      logic [CNTW-1:0]   cnt_reg;
      logic              lvl;
      logic              rise;
      logic              fall;
      logic              det;
      logic              hold_busy;
      logic              fire;
      logic              drop_hit;

      assign lvl  = sync_reg[STAGES-1];
      assign rise = lvl & ~prev_reg;
      assign fall = ~lvl & prev_reg;
      assign det  = (MODE == 0) ? rise : (MODE == 1) ? fall : (rise | fall);

      // Edges only count once primed and while the channel is enabled; the
      // holdoff then decides between issuing a pulse and dropping the edge.
      assign fire     = det & en_i[gi] & primed & ~hold_busy;
      assign drop_hit = det & en_i[gi] & primed & hold_busy;

      // Synchroniser chain plus the edge register holding the previous level.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= '0;
          prev_reg <= 1'b0;
        end else begin
          sync_reg <= {sync_reg[STAGES-2:0], async_i[gi]};
          prev_reg <= lvl;
        end
      end

      // Registered pulse and drop strobes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pulse_reg <= 1'b0;
          drop_reg  <= 1'b0;
        end else begin
          pulse_reg <= fire;
          drop_reg  <= drop_hit;
        end
      end

      // Saturating drop counter; a clear overrides a same-cycle drop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
        end else if (clr_i) begin
          cnt_reg <= '0;
        end else if (drop_hit && (cnt_reg != CNT_MAX)) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      if (HOLDOFF > 0) begin : g_hold
        localparam int HW = $clog2(HOLDOFF + 1);
        logic [HW-1:0] hold_reg;

        assign hold_busy = (hold_reg != '0);

        // Hold counter: reloads on an issued pulse, otherwise drains to zero.
        // Dropped edges deliberately leave it alone.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            hold_reg <= '0;
          end else if (fire) begin
            hold_reg <= HW'(HOLDOFF);
          end else if (hold_reg != '0) begin
            hold_reg <= hold_reg - 1'b1;
          end
        end
      end else begin : g_nohold
        assign hold_busy = 1'b0;
      end

      assign o[gi]                       = pulse_reg;
      assign drop_o[gi]                  = drop_reg;
      assign lvl_o[gi]                   = lvl;
      assign drop_cnt[gi*CNTW +: CNTW]   = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_xd_pulse_sync.sv
// Bench for xd_pulse_sync: three instances with different STAGES/MODE/HOLDOFF/
// CNTW share one stimulus stream. The driver computes expected outputs from a
// cycle-history reference model and queues them; a monitor pops and compares.
module tb_xd_pulse_sync;

  // Per-instance configuration: A, B, C.
  localparam int S_P [3] = '{2, 3, 2};
  localparam int M_P [3] = '{0, 2, 1};
  localparam int H_P [3] = '{3, 0, 15};
  localparam int W_P [3] = '{8, 8, 2};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  async_i = 4'h0;
  logic [3:0]  en_i = 4'h0;
  logic        clr_i = 1'b0;

  logic [3:0]  o_a, lvl_a, drop_a;
  logic [3:0]  o_b, lvl_b, drop_b;
  logic [3:0]  o_c, lvl_c, drop_c;
  logic [31:0] cnt_a, cnt_b;
  logic [7:0]  cnt_c;

  typedef struct packed {
    logic [3:0]  o;
    logic [3:0]  drop;
    logic [3:0]  lvl;
    logic [31:0] cnt;
  } exp_t;
  typedef exp_t [2:0] cyc_t;

  cyc_t       sbq[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         done = 1'b0;

  // Reference model state: input history since release, last pulse cycle,
  // and drop counts per instance/channel.
  logic [3:0] hist[$];
  int         ncyc;
  int         last_p [3][4];
  int         cnt_m [3][4];
  logic [3:0] ra;
  logic [3:0] re;

  always #5 clk = ~clk;

  xd_pulse_sync #(.CH(4), .STAGES(2), .MODE(0), .HOLDOFF(3), .CNTW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .async_i(async_i), .en_i(en_i), .clr_i(clr_i),
    .o(o_a), .lvl_o(lvl_a), .drop_o(drop_a), .drop_cnt(cnt_a));

  xd_pulse_sync #(.CH(4), .STAGES(3), .MODE(2), .HOLDOFF(0), .CNTW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .async_i(async_i), .en_i(en_i), .clr_i(clr_i),
    .o(o_b), .lvl_o(lvl_b), .drop_o(drop_b), .drop_cnt(cnt_b));

  xd_pulse_sync #(.CH(4), .STAGES(2), .MODE(1), .HOLDOFF(15), .CNTW(2)) u_c (
    .clk(clk), .rst_n(rst_n), .async_i(async_i), .en_i(en_i), .clr_i(clr_i),
    .o(o_c), .lvl_o(lvl_c), .drop_o(drop_c), .drop_cnt(cnt_c));

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s inst%0d t=%0t: got %0h, expected %0h", name, inst, $time, act, req);
    end
  endtask

  function automatic exp_t actual(input int i);
    exp_t r;
    case (i)
      0:       r = '{o: o_a, drop: drop_a, lvl: lvl_a, cnt: cnt_a};
      1:       r = '{o: o_b, drop: drop_b, lvl: lvl_b, cnt: cnt_b};
      default: r = '{o: o_c, drop: drop_c, lvl: lvl_c, cnt: {24'h0, cnt_c}};
    endcase
    return r;
  endfunction

  function automatic logic [3:0] in_at(input int m);
    if (m < 1) return 4'h0;
    return hist[m-1];
  endfunction

  task automatic model_reset();
    ncyc = 0;
    hist.delete();
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) begin
        last_p[i][c] = -1000;
        cnt_m[i][c]  = 0;
      end
    end
  endtask

  // One clock of stimulus: predict the outputs after the next rising edge from
  // the input history, queue them, then drive the inputs.
  task automatic step(input logic [3:0] a, input logic [3:0] e, input bit clr,
                      input bit clr_on_drop);
    cyc_t       ex;
    logic [3:0] curv, prvv;
    bit         cur, prv, det, clr_v;
    @(negedge clk);
    ex = '0;
    ncyc++;
    hist.push_back(a);
    for (int i = 0; i < 3; i++) begin
      curv = in_at(ncyc - S_P[i]);
      prvv = in_at(ncyc - S_P[i] - 1);
      for (int c = 0; c < 4; c++) begin
        cur = curv[c];
        prv = prvv[c];
        case (M_P[i])
          0:       det = cur && !prv;
          1:       det = !cur && prv;
          default: det = (cur != prv);
        endcase
        if (det && e[c] && ncyc >= S_P[i] + 2) begin
          if (H_P[i] == 0 || ncyc - last_p[i][c] > H_P[i]) begin
            ex[i].o[c]   = 1'b1;
            last_p[i][c] = ncyc;
          end else begin
            ex[i].drop[c] = 1'b1;
            if (cnt_m[i][c] < (1 << W_P[i]) - 1) cnt_m[i][c]++;
          end
        end
      end
    end
    clr_v = clr || (clr_on_drop && ex[2].drop[3]);
    for (int i = 0; i < 3; i++) begin
      ex[i].lvl = in_at(ncyc - S_P[i] + 1);
      for (int c = 0; c < 4; c++) begin
        if (clr_v) cnt_m[i][c] = 0;
        ex[i].cnt = ex[i].cnt | (32'(cnt_m[i][c]) << (c * W_P[i]));
      end
    end
    async_i = a;
    en_i    = e;
    clr_i   = clr_v;
    sbq.push_back(ex);
  endtask

  // Assert reset mid-cycle, check the outputs clear without a clock edge, hold
  // it for the given number of edges and release just after a rising edge.
  task automatic do_reset(input logic [3:0] a, input int cycles);
    cyc_t z;
    exp_t act;
    z = '0;
    @(negedge clk);
    async_i = a;
    model_reset();
    sbq.push_back(z);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      act = actual(i);
      chk("async_rst_o", i, 32'(act.o), 32'h0);
      chk("async_rst_drop", i, 32'(act.drop), 32'h0);
      chk("async_rst_lvl", i, 32'(act.lvl), 32'h0);
      chk("async_rst_cnt", i, act.cnt, 32'h0);
    end
    for (int k = 1; k < cycles; k++) begin
      @(negedge clk);
      sbq.push_back(z);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // Monitor: every cycle the DUTs present outputs; compare against the queue.
  initial begin
    cyc_t x;
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        for (int i = 0; i < 3; i++) begin
          act = actual(i);
          chk("o", i, 32'(act.o), 32'(x[i].o));
          chk("drop_o", i, 32'(act.drop), 32'(x[i].drop));
          chk("lvl_o", i, 32'(act.lvl), 32'(x[i].lvl));
          chk("drop_cnt", i, act.cnt, x[i].cnt);
        end
      end
    end
  end

  // Stimulus: directed scenarios first, then a randomized phase.
  initial begin
    // Inputs high through reset must never pulse.
    do_reset(4'hF, 3);
    repeat (20) step(4'hF, 4'hF, 1'b0, 1'b0);
    repeat (8) step(4'h0, 4'hF, 1'b0, 1'b0);

    // Single rising edge on ch0 held for 10 cycles.
    repeat (10) step(4'h1, 4'hF, 1'b0, 1'b0);
    repeat (6) step(4'h0, 4'hF, 1'b0, 1'b0);

    // ch1 toggles every 5 cycles, 4 times.
    ra = 4'h0;
    for (int t = 0; t < 4; t++) begin
      ra[1] = ~ra[1];
      repeat (5) step(ra, 4'hF, 1'b0, 1'b0);
    end

    // ch2 edges 2 cycles apart (second dropped on A), then 4 apart (both pulse).
    step(4'h4, 4'hF, 1'b0, 1'b0);
    step(4'h0, 4'hF, 1'b0, 1'b0);
    step(4'h4, 4'hF, 1'b0, 1'b0);
    repeat (8) step(4'h0, 4'hF, 1'b0, 1'b0);
    step(4'h4, 4'hF, 1'b0, 1'b0);
    repeat (3) step(4'h0, 4'hF, 1'b0, 1'b0);
    step(4'h4, 4'hF, 1'b0, 1'b0);
    repeat (8) step(4'h0, 4'hF, 1'b0, 1'b0);

    // Fast ch3 toggling: repeated drops saturate C's 2-bit counter, then a
    // clear lands exactly on a drop cycle.
    ra = 4'h0;
    for (int t = 0; t < 14; t++) begin
      ra[3] = ~ra[3];
      step(ra, 4'hF, 1'b0, 1'b0);
    end
    for (int t = 0; t < 4; t++) begin
      ra[3] = ~ra[3];
      step(ra, 4'hF, 1'b0, 1'b1);
    end
    repeat (20) step(4'h0, 4'hF, 1'b0, 1'b0);

    // ch0 edge while disabled, then re-enable: nothing replayed.
    repeat (6) step(4'h1, 4'hE, 1'b0, 1'b0);
    repeat (4) step(4'h1, 4'hF, 1'b0, 1'b0);
    repeat (20) step(4'h0, 4'hF, 1'b0, 1'b0);

    // Reset mid-holdoff with ch2 still high: no pulse after release.
    repeat (3) step(4'h4, 4'hF, 1'b0, 1'b0);
    do_reset(4'h4, 3);
    repeat (12) step(4'h4, 4'hF, 1'b0, 1'b0);

    // Randomized phase with occasional disables, clears and resets.
    ra = 4'h4;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 3) == 0) ra[c] = ~ra[c];
      end
      re = 4'hF;
      if ($urandom_range(0, 9) == 0) re[$urandom_range(0, 3)] = 1'b0;
      step(ra, re, ($urandom_range(0, 49) == 0), 1'b0);
      if (k % 500 == 499) do_reset(ra, 2);
    end
    repeat (4) step(ra, 4'hF, 1'b0, 1'b0);

    @(posedge clk);
    #2;
    chk("sb_drained", 0, 32'(sbq.size()), 32'h0);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
